// File: rtl/apb_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_ctrl_pkg : shared types and sizes for the APB master arbiter |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int NUM_REQ         = 2;
    localparam int DATA_W          = 8;
    localparam int TIMEOUT_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb2  : two-way round-robin arbiter, priority flips on advance |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module rr_arb2
    import apb_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               grant
);

    // Index of the requester that wins a tie
    logic prio;

    always_comb begin
        grant = prio;
        if (!req[prio] && req[~prio]) begin
            grant = ~prio;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= ~grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb_master_arb : two-requester APB master with round-robin grant |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module apb_master_arb
    import apb_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      pclk,
    input  logic                      prst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    // Wait count at which the current ACCESS cycle is the last one allowed
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    apb_state_t        state;
    apb_state_t        next_state;
    logic              gnt;
    logic              gnt_q;
    logic              accept;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_arb (
        .clk     (pclk),
        .rst     (prst),
        .req     (req_valid),
        .advance (accept),
        .grant   (gnt)
    );

    assign sel_addr  = gnt ? req_addr[2*DATA_W-1:DATA_W]  : req_addr[DATA_W-1:0];
    assign sel_wdata = gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        psel       = 1'b0;
        penable    = 1'b0;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    accept         = 1'b1;
                    req_ready[gnt] = 1'b1;
                    next_state     = SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || (wait_cnt == TMO_LAST)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            gnt_q     <= 1'b0;
            wait_cnt  <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        paddr  <= sel_addr;
                        pwdata <= sel_wdata;
                        pwrite <= req_write[gnt];
                        gnt_q  <= gnt;
                    end
                end
                SETUP: wait_cnt <= '0;
                ACCESS: begin
                    if (pready) begin
                        rsp_valid[gnt_q] <= 1'b1;
                        rsp_rdata        <= pwrite ? '0 : prdata;
                        rsp_err          <= pslverr;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // Timed out: complete with an error and no data
                        if (wait_cnt == TMO_LAST) begin
                            rsp_valid[gnt_q] <= 1'b1;
                            rsp_rdata        <= '0;
                            rsp_err          <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_apb_master_arb : directed self-checking bench for the arbiter |
// | Revision          : 1.0                                          |
// +------------------------------------------------------------------+
module tb_apb_master_arb;

    logic        pclk = 1'b0;
    logic        prst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [7:0]  pwdata;
    logic [7:0]  prdata  = '0;
    logic        pready  = 1'b0;
    logic        pslverr = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 pclk = ~pclk;

    apb_master_arb #(.TIMEOUT(16)) dut (
        .pclk      (pclk),
        .prst      (prst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    task automatic test_reset();
        prst = 1'b1;
        repeat (2) @(negedge pclk);
        #1;
        n_cmp++;
        if ({psel, penable, pwrite} !== 3'b000) begin
            n_fail++; $display("FAIL rst_ctrl: got %b want 000", {psel, penable, pwrite});
        end
        n_cmp++;
        if ({paddr, pwdata} !== 16'h0000) begin
            n_fail++; $display("FAIL rst_addr_data: got %h want 0000", {paddr, pwdata});
        end
        n_cmp++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== 11'd0) begin
            n_fail++; $display("FAIL rst_rsp: got %h want 000", {rsp_valid, rsp_rdata, rsp_err});
        end
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL rst_ready: got %b want 00", req_ready);
        end
        @(negedge pclk);
        prst = 1'b0;
    endtask

    task automatic test_write0();
        @(negedge pclk);
        req_valid = 2'b01; req_write = 2'b01; req_addr = 16'h0005; req_wdata = 16'h00A5;
        pready = 1'b1; prdata = 8'h33; pslverr = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01 || psel !== 1'b0) begin
            n_fail++; $display("FAIL wr_accept: ready=%b psel=%b want 01/0", req_ready, psel);
        end
        @(negedge pclk); req_valid = 2'b00; #1;
        n_cmp++;
        if ({psel, penable, pwrite} !== 3'b101) begin
            n_fail++; $display("FAIL wr_setup_ctrl: got %b want 101", {psel, penable, pwrite});
        end
        n_cmp++;
        if (paddr !== 8'h05 || pwdata !== 8'hA5) begin
            n_fail++; $display("FAIL wr_setup_addr: got %h/%h want 05/a5", paddr, pwdata);
        end
        @(negedge pclk); #1;
        n_cmp++;
        if ({psel, penable} !== 2'b11 || rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL wr_access: sel/en=%b rsp=%b want 11/00", {psel, penable}, rsp_valid);
        end
        @(negedge pclk); #1;
        n_cmp++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
            n_fail++; $display("FAIL wr_rsp: got %b/%b/%h want 01/0/00", rsp_valid, rsp_err, rsp_rdata);
        end
        n_cmp++;
        if (psel !== 1'b0 || paddr !== 8'h05) begin
            n_fail++; $display("FAIL wr_idle_hold: psel=%b paddr=%h want 0/05", psel, paddr);
        end
    endtask

    task automatic test_read1_wait();
        @(negedge pclk);
        req_valid = 2'b10; req_write = 2'b00; req_addr = 16'h0500;
        pready = 1'b0; prdata = 8'hA5;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL rd_accept: got %b want 10", req_ready);
        end
        @(negedge pclk); req_valid = 2'b00; #1;
        n_cmp++;
        if ({psel, penable, pwrite} !== 3'b100 || paddr !== 8'h05) begin
            n_fail++; $display("FAIL rd_setup: ctrl=%b paddr=%h want 100/05", {psel, penable, pwrite}, paddr);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk); #1;
            n_cmp++;
            if ({psel, penable} !== 2'b11 || paddr !== 8'h05 || rsp_valid !== 2'b00) begin
                n_fail++; $display("FAIL rd_wait%0d: sel/en=%b paddr=%h rsp=%b want 11/05/00",
                                   i, {psel, penable}, paddr, rsp_valid);
            end
        end
        @(negedge pclk); pready = 1'b1; #1;
        n_cmp++;
        if ({psel, penable} !== 2'b11 || paddr !== 8'h05) begin
            n_fail++; $display("FAIL rd_ready_cyc: sel/en=%b paddr=%h want 11/05", {psel, penable}, paddr);
        end
        @(negedge pclk); pready = 1'b0; #1;
        n_cmp++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0 || psel !== 1'b0) begin
            n_fail++; $display("FAIL rd_rsp: got %b/%h/%b psel=%b want 10/a5/0 psel=0",
                               rsp_valid, rsp_rdata, rsp_err, psel);
        end
        @(negedge pclk); #1;
        n_cmp++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL rd_rsp_hold: got %b/%h want 00/a5", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_ready;
        logic [1:0] exp_rsp;
        logic       exp_psel;
        logic       exp_pen;
        logic [7:0] exp_addr;
        @(negedge pclk); prst = 1'b1;
        @(negedge pclk); prst = 1'b0;
        req_write = 2'b11; req_addr = 16'h2110; req_wdata = 16'hB2A1;
        pready = 1'b1; pslverr = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge pclk);
            req_valid = (k < 12) ? 2'b11 : 2'b00;
            #1;
            exp_ready = (k % 3 == 0 && k < 12) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rsp   = (k >= 3 && k % 3 == 0) ? ((((k / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_psel  = (k % 3 != 0);
            exp_pen   = (k % 3 == 2);
            n_cmp++;
            if (req_ready !== exp_ready || rsp_valid !== exp_rsp) begin
                n_fail++; $display("FAIL b2b_k%0d: ready=%b rsp=%b want %b/%b",
                                   k, req_ready, rsp_valid, exp_ready, exp_rsp);
            end
            n_cmp++;
            if (psel !== exp_psel || penable !== exp_pen) begin
                n_fail++; $display("FAIL b2b_apb_k%0d: sel/en=%b%b want %b%b",
                                   k, psel, penable, exp_psel, exp_pen);
            end
            if (k % 3 == 1) begin
                exp_addr = (((k - 1) / 3) % 2 == 0) ? 8'h10 : 8'h21;
                n_cmp++;
                if (paddr !== exp_addr) begin
                    n_fail++; $display("FAIL b2b_addr_k%0d: got %h want %h", k, paddr, exp_addr);
                end
            end
        end
    endtask

    task automatic test_timeout();
        @(negedge pclk);
        req_valid = 2'b01; req_write = 2'b00; req_addr = 16'h0040;
        pready = 1'b0; prdata = 8'h77;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL to_accept: got %b want 01", req_ready);
        end
        @(negedge pclk); req_valid = 2'b00; #1;
        n_cmp++;
        if ({psel, penable} !== 2'b10) begin
            n_fail++; $display("FAIL to_setup: got %b want 10", {psel, penable});
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge pclk); #1;
            n_cmp++;
            if ({psel, penable, rsp_valid} !== 4'b1100) begin
                n_fail++; $display("FAIL to_access%0d: sel/en/rsp=%b want 1100", i, {psel, penable, rsp_valid});
            end
        end
        @(negedge pclk); #1;
        n_cmp++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || psel !== 1'b0) begin
            n_fail++; $display("FAIL to_rsp: got %b/%b/%h psel=%b want 01/1/00 psel=0",
                               rsp_valid, rsp_err, rsp_rdata, psel);
        end
    endtask

    task automatic test_slverr();
        @(negedge pclk);
        req_valid = 2'b10; req_write = 2'b00; req_addr = 16'hC900;
        pready = 1'b1; pslverr = 1'b1; prdata = 8'h5A;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL se_accept: got %b want 10", req_ready);
        end
        @(negedge pclk); req_valid = 2'b00; #1;
        n_cmp++;
        if (paddr !== 8'hC9 || psel !== 1'b1) begin
            n_fail++; $display("FAIL se_setup: paddr=%h psel=%b want c9/1", paddr, psel);
        end
        @(negedge pclk); #1;
        @(negedge pclk); #1;
        n_cmp++;
        if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_rdata !== 8'h5A) begin
            n_fail++; $display("FAIL se_rsp: got %b/%b/%h want 10/1/5a", rsp_valid, rsp_err, rsp_rdata);
        end
        pslverr = 1'b0;
    endtask

    task automatic test_reset_access();
        @(negedge pclk);
        req_valid = 2'b01; req_write = 2'b01; req_addr = 16'h0012; req_wdata = 16'h0034;
        pready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL ra_accept: got %b want 01", req_ready);
        end
        @(negedge pclk); req_valid = 2'b00;
        @(negedge pclk); #1;
        n_cmp++;
        if ({psel, penable} !== 2'b11) begin
            n_fail++; $display("FAIL ra_in_access: got %b want 11", {psel, penable});
        end
        prst = 1'b1;
        #1;
        n_cmp++;
        if ({psel, penable} !== 2'b00 || rsp_valid !== 2'b00 || paddr !== 8'h00) begin
            n_fail++; $display("FAIL ra_async: sel/en=%b rsp=%b paddr=%h want 00/00/00",
                               {psel, penable}, rsp_valid, paddr);
        end
        @(negedge pclk); #1;
        n_cmp++;
        if (rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL ra_no_rsp: got %b want 00", rsp_valid);
        end
        @(negedge pclk);
        prst = 1'b0; req_valid = 2'b11; req_addr = 16'h3456; pready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL ra_prio: got %b want 01", req_ready);
        end
        @(negedge pclk); req_valid = 2'b00; #1;
        n_cmp++;
        if (psel !== 1'b1 || paddr !== 8'h56) begin
            n_fail++; $display("FAIL ra_first_accept: psel=%b paddr=%h want 1/56", psel, paddr);
        end
        @(negedge pclk); #1;
        @(negedge pclk); #1;
        n_cmp++;
        if (rsp_valid !== 2'b01) begin
            n_fail++; $display("FAIL ra_rsp: got %b want 01", rsp_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write0();
        test_read1_wait();
        test_back_to_back();
        test_timeout();
        test_slverr();
        test_reset_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
